// File: rtl/chess_pkg.sv
// ============================================================================
// Module   : chess_pkg
// Brief    : Shared state, winner and player encodings for the chess clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_P1 = 3'd1,
        ST_RUN_P2 = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;

    localparam logic c_P1 = 1'b0;
    localparam logic c_P2 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/game_controller_if.sv
// ============================================================================
// Module   : game_controller_if
// Brief    : Button/timeout inputs and switch/countdown controls of the clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_controller_if #(
    parameter int MOVE_W = 10
);
    logic              BTN_START;
    logic              BTN_PAUSE;
    logic              BTN_P1;
    logic              BTN_P2;
    logic              TIMEOUT_P1;
    logic              TIMEOUT_P2;
    logic              SELECT;
    logic              STOP;
    logic              END;
    logic              INC_P1;
    logic              INC_P2;
    logic [MOVE_W-1:0] MOVES;
    logic [1:0]        WINNER;
    logic [2:0]        STATE;

    modport master (
        output BTN_START, BTN_PAUSE, BTN_P1, BTN_P2, TIMEOUT_P1, TIMEOUT_P2,
        input  SELECT, STOP, END, INC_P1, INC_P2, MOVES, WINNER, STATE
    );

    modport slave (
        input  BTN_START, BTN_PAUSE, BTN_P1, BTN_P2, TIMEOUT_P1, TIMEOUT_P2,
        output SELECT, STOP, END, INC_P1, INC_P2, MOVES, WINNER, STATE
    );
endinterface

`default_nettype wire

// File: rtl/game_controller_edge_detect.sv
// ============================================================================
// Module   : edge_detect
// Brief    : Registered rising-edge pulse; previous sample presets to 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect (
    input  wire logic CLK,
    input  wire logic CLR_N,
    input  wire logic i_din,
    output logic      o_pulse
);

    logic r_prev;
    logic r_pulse;

    // Preset of 1 keeps a button held through reset from looking like a press
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_din;
            r_pulse <= i_din & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// ============================================================================
// Module   : game_controller
// Brief    : Chess-clock turn sequencer with Fischer pulses and move counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_controller #(
    parameter int MOVE_W = 10,
    parameter bit INC_EN = 1'b1
) (
    input  wire logic       CLK,
    input  wire logic       CLR_N,
    game_controller_if.slave bus
);
    import chess_pkg::*;

    logic w_start_p, w_pause_p, w_p1_p, w_p2_p;

    edge_detect u_ed_start (.CLK(CLK), .CLR_N(CLR_N), .i_din(bus.BTN_START), .o_pulse(w_start_p));
    edge_detect u_ed_pause (.CLK(CLK), .CLR_N(CLR_N), .i_din(bus.BTN_PAUSE), .o_pulse(w_pause_p));
    edge_detect u_ed_p1    (.CLK(CLK), .CLR_N(CLR_N), .i_din(bus.BTN_P1),    .o_pulse(w_p1_p));
    edge_detect u_ed_p2    (.CLK(CLK), .CLR_N(CLR_N), .i_din(bus.BTN_P2),    .o_pulse(w_p2_p));

    state_t            r_state,  w_state_n;
    logic              r_paused_player, w_paused_player_n;
    logic              r_select, w_select_n;
    logic              r_stop,   w_stop_n;
    logic              r_end,    w_end_n;
    logic              r_inc_p1, w_inc_p1_n;
    logic              r_inc_p2, w_inc_p2_n;
    logic [MOVE_W-1:0] r_moves,  w_moves_n, w_moves_inc;
    logic [1:0]        r_winner, w_winner_n;

    assign w_moves_inc = (&r_moves) ? r_moves : r_moves + MOVE_W'(1);

    always_comb begin
        w_state_n         = r_state;
        w_paused_player_n = r_paused_player;
        w_inc_p1_n        = 1'b0;
        w_inc_p2_n        = 1'b0;
        w_moves_n         = r_moves;
        w_winner_n        = r_winner;

        // Order inside each RUN state encodes priority: timeout, pause, turn press
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_p) begin
                    w_state_n  = ST_RUN_P1;
                    w_moves_n  = '0;
                    w_winner_n = c_WIN_NONE;
                end
            end
            ST_RUN_P1: begin
                if (bus.TIMEOUT_P1) begin
                    w_state_n  = ST_OVER;
                    w_winner_n = c_WIN_P2;
                end else if (w_pause_p) begin
                    w_state_n         = ST_PAUSED;
                    w_paused_player_n = c_P1;
                end else if (w_p1_p) begin
                    w_state_n  = ST_RUN_P2;
                    w_inc_p1_n = INC_EN;
                    w_moves_n  = w_moves_inc;
                end
            end
            ST_RUN_P2: begin
                if (bus.TIMEOUT_P2) begin
                    w_state_n  = ST_OVER;
                    w_winner_n = c_WIN_P1;
                end else if (w_pause_p) begin
                    w_state_n         = ST_PAUSED;
                    w_paused_player_n = c_P2;
                end else if (w_p2_p) begin
                    w_state_n  = ST_RUN_P1;
                    w_inc_p2_n = INC_EN;
                    w_moves_n  = w_moves_inc;
                end
            end
            ST_PAUSED: begin
                if (w_pause_p) begin
                    w_state_n = (r_paused_player == c_P2) ? ST_RUN_P2 : ST_RUN_P1;
                end
            end
            ST_OVER: begin
                if (w_start_p) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // Moore decode from the next state so outputs register alongside it
        w_select_n = r_select;
        if (w_state_n == ST_RUN_P1) begin
            w_select_n = 1'b0;
        end else if (w_state_n == ST_RUN_P2) begin
            w_select_n = 1'b1;
        end
        w_stop_n = !((w_state_n == ST_RUN_P1) || (w_state_n == ST_RUN_P2));
        w_end_n  = (w_state_n == ST_OVER);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state         <= ST_IDLE;
            r_paused_player <= c_P1;
            r_select        <= 1'b0;
            r_stop          <= 1'b1;
            r_end           <= 1'b0;
            r_inc_p1        <= 1'b0;
            r_inc_p2        <= 1'b0;
            r_moves         <= '0;
            r_winner        <= c_WIN_NONE;
        end else begin
            r_state         <= w_state_n;
            r_paused_player <= w_paused_player_n;
            r_select        <= w_select_n;
            r_stop          <= w_stop_n;
            r_end           <= w_end_n;
            r_inc_p1        <= w_inc_p1_n;
            r_inc_p2        <= w_inc_p2_n;
            r_moves         <= w_moves_n;
            r_winner        <= w_winner_n;
        end
    end

    assign bus.SELECT = r_select;
    assign bus.STOP   = r_stop;
    assign bus.END    = r_end;
    assign bus.INC_P1 = r_inc_p1;
    assign bus.INC_P2 = r_inc_p2;
    assign bus.MOVES  = r_moves;
    assign bus.WINNER = r_winner;
    assign bus.STATE  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ============================================================================
// Module   : tb_game_controller
// Brief    : Directed checks of game_controller (10-bit counter and 2-bit/no-inc).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_controller;

    localparam int c_B_START = 0;
    localparam int c_B_PAUSE = 1;
    localparam int c_B_P1    = 2;
    localparam int c_B_P2    = 3;

    logic CLK = 1'b0;
    logic CLR_N = 1'b1;
    logic btn_start = 1'b0, btn_pause = 1'b0, btn_p1 = 1'b0, btn_p2 = 1'b0;
    logic to_p1 = 1'b0, to_p2 = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    game_controller_if #(.MOVE_W(10)) bus_a ();
    game_controller_if #(.MOVE_W(2))  bus_b ();

    assign bus_a.BTN_START = btn_start;  assign bus_b.BTN_START = btn_start;
    assign bus_a.BTN_PAUSE = btn_pause;  assign bus_b.BTN_PAUSE = btn_pause;
    assign bus_a.BTN_P1    = btn_p1;     assign bus_b.BTN_P1    = btn_p1;
    assign bus_a.BTN_P2    = btn_p2;     assign bus_b.BTN_P2    = btn_p2;
    assign bus_a.TIMEOUT_P1 = to_p1;     assign bus_b.TIMEOUT_P1 = to_p1;
    assign bus_a.TIMEOUT_P2 = to_p2;     assign bus_b.TIMEOUT_P2 = to_p2;

    game_controller #(.MOVE_W(10), .INC_EN(1'b1)) dut   (.CLK(CLK), .CLR_N(CLR_N), .bus(bus_a));
    game_controller #(.MOVE_W(2),  .INC_EN(1'b0)) dut_s (.CLK(CLK), .CLR_N(CLR_N), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_btn(input int id, input logic v);
        case (id)
            c_B_START: btn_start = v;
            c_B_PAUSE: btn_pause = v;
            c_B_P1:    btn_p1    = v;
            default:   btn_p2    = v;
        endcase
    endtask

    // Raise a button and wait until the registered press has taken effect
    task automatic press(input int id);
        set_btn(id, 1'b1);
        tick();
        tick();
    endtask

    task automatic rel(input int id);
        set_btn(id, 1'b0);
        tick();
    endtask

    initial begin
        #2 CLR_N = 1'b0;
        #1;
        chk("rst_state",  bus_a.STATE,  3'd0);
        chk("rst_stop",   bus_a.STOP,   1'b1);
        chk("rst_select", bus_a.SELECT, 1'b0);
        chk("rst_end",    bus_a.END,    1'b0);
        chk("rst_moves",  bus_a.MOVES,  10'd0);
        chk("rst_winner", bus_a.WINNER, 2'b00);
        chk("rst_inc1",   bus_a.INC_P1, 1'b0);
        tick(); tick();
        CLR_N = 1'b1;
        tick();

        // START: one cycle latency through the edge register
        btn_start = 1'b1;
        tick();
        chk("start_k_state", bus_a.STATE, 3'd0);
        tick();
        chk("start_state",  bus_a.STATE,  3'd1);
        chk("start_select", bus_a.SELECT, 1'b0);
        chk("start_stop",   bus_a.STOP,   1'b0);
        chk("start_end",    bus_a.END,    1'b0);
        chk("start_moves",  bus_a.MOVES,  10'd0);
        rel(c_B_START);

        press(c_B_P2);
        chk("p2_ign_state", bus_a.STATE,  3'd1);
        chk("p2_ign_moves", bus_a.MOVES,  10'd0);
        chk("p2_ign_inc",   bus_a.INC_P2, 1'b0);
        rel(c_B_P2);

        press(c_B_P1);
        chk("p1_state",   bus_a.STATE,  3'd2);
        chk("p1_select",  bus_a.SELECT, 1'b1);
        chk("p1_inc",     bus_a.INC_P1, 1'b1);
        chk("p1_moves",   bus_a.MOVES,  10'd1);
        chk("s_p1_inc",   bus_b.INC_P1, 1'b0);
        chk("s_moves1",   bus_b.MOVES,  2'd1);
        rel(c_B_P1);
        chk("p1_inc_off", bus_a.INC_P1, 1'b0);

        press(c_B_P2);
        chk("p2_select",  bus_a.SELECT, 1'b0);
        chk("p2_inc",     bus_a.INC_P2, 1'b1);
        chk("p2_moves",   bus_a.MOVES,  10'd2);
        rel(c_B_P2);
        chk("p2_inc_off", bus_a.INC_P2, 1'b0);
        chk("p2_state",   bus_a.STATE,  3'd1);

        press(c_B_P1);
        chk("m3_moves",   bus_a.MOVES,  10'd3);
        chk("s_moves3",   bus_b.MOVES,  2'd3);
        rel(c_B_P1);

        // Pause in RUN_P2, ignored press and timeout, resume
        press(c_B_PAUSE);
        chk("pause_state",  bus_a.STATE,  3'd3);
        chk("pause_stop",   bus_a.STOP,   1'b1);
        chk("pause_select", bus_a.SELECT, 1'b1);
        rel(c_B_PAUSE);
        press(c_B_P2);
        chk("pause_p2_state", bus_a.STATE,  3'd3);
        chk("pause_p2_moves", bus_a.MOVES,  10'd3);
        chk("pause_p2_inc",   bus_a.INC_P2, 1'b0);
        rel(c_B_P2);
        to_p2 = 1'b1;
        tick();
        chk("pause_to_state", bus_a.STATE, 3'd3);
        to_p2 = 1'b0;
        press(c_B_PAUSE);
        chk("resume_state",  bus_a.STATE,  3'd2);
        chk("resume_stop",   bus_a.STOP,   1'b0);
        chk("resume_select", bus_a.SELECT, 1'b1);
        rel(c_B_PAUSE);

        press(c_B_P2);
        chk("m4_moves", bus_a.MOVES, 10'd4);
        chk("s_sat4",   bus_b.MOVES, 2'd3);
        rel(c_B_P2);
        press(c_B_P1);
        chk("m5_moves", bus_a.MOVES, 10'd5);
        chk("s_sat5",   bus_b.MOVES, 2'd3);
        rel(c_B_P1);
        press(c_B_P2);
        chk("m6_state", bus_a.STATE, 3'd1);
        chk("m6_moves", bus_a.MOVES, 10'd6);
        rel(c_B_P2);

        // Timeout wins over a coincident turn press
        to_p1  = 1'b1;
        btn_p1 = 1'b1;
        tick();
        chk("to1_state",  bus_a.STATE,  3'd4);
        chk("to1_end",    bus_a.END,    1'b1);
        chk("to1_stop",   bus_a.STOP,   1'b1);
        chk("to1_winner", bus_a.WINNER, 2'b10);
        chk("to1_select", bus_a.SELECT, 1'b0);
        chk("to1_inc",    bus_a.INC_P1, 1'b0);
        tick();
        chk("to1_inc2",   bus_a.INC_P1, 1'b0);
        chk("to1_moves",  bus_a.MOVES,  10'd6);
        to_p1  = 1'b0;
        btn_p1 = 1'b0;
        tick();

        press(c_B_START);
        chk("over_idle_state",  bus_a.STATE,  3'd0);
        chk("over_idle_winner", bus_a.WINNER, 2'b10);
        chk("over_idle_moves",  bus_a.MOVES,  10'd6);
        chk("over_idle_end",    bus_a.END,    1'b0);
        chk("over_idle_stop",   bus_a.STOP,   1'b1);
        rel(c_B_START);
        press(c_B_START);
        chk("restart_state",  bus_a.STATE,  3'd1);
        chk("restart_moves",  bus_a.MOVES,  10'd0);
        chk("restart_winner", bus_a.WINNER, 2'b00);
        chk("s_restart_moves", bus_b.MOVES, 2'd0);
        rel(c_B_START);

        press(c_B_P1);
        rel(c_B_P1);
        to_p2 = 1'b1;
        tick();
        chk("to2_state",  bus_a.STATE,  3'd4);
        chk("to2_winner", bus_a.WINNER, 2'b01);
        chk("to2_select", bus_a.SELECT, 1'b1);
        to_p2 = 1'b0;
        tick();

        press(c_B_START); rel(c_B_START);
        press(c_B_START); rel(c_B_START);
        press(c_B_P1);    rel(c_B_P1);
        chk("pre_rst_state", bus_a.STATE, 3'd2);

        // Asynchronous reset mid RUN_P2 with P2 held
        btn_p2 = 1'b1;
        CLR_N  = 1'b0;
        #1;
        chk("mid_rst_state",  bus_a.STATE,  3'd0);
        chk("mid_rst_stop",   bus_a.STOP,   1'b1);
        chk("mid_rst_select", bus_a.SELECT, 1'b0);
        chk("mid_rst_moves",  bus_a.MOVES,  10'd0);
        chk("mid_rst_inc",    bus_a.INC_P2, 1'b0);
        tick();
        CLR_N = 1'b1;
        tick();
        press(c_B_START); rel(c_B_START);
        press(c_B_P1);    rel(c_B_P1);
        tick(); tick(); tick();
        chk("held_p2_state", bus_a.STATE, 3'd2);
        chk("held_p2_moves", bus_a.MOVES, 10'd1);
        btn_p2 = 1'b0;
        tick();
        press(c_B_P2);
        chk("repress_state", bus_a.STATE,  3'd1);
        chk("repress_moves", bus_a.MOVES,  10'd2);
        chk("repress_inc",   bus_a.INC_P2, 1'b1);
        rel(c_B_P2);

        // START held across reset must not start a game
        btn_start = 1'b1;
        CLR_N     = 1'b0;
        tick();
        CLR_N = 1'b1;
        tick(); tick(); tick();
        chk("held_start_state", bus_a.STATE, 3'd0);
        btn_start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_controller.md
# game_controller

Turn-sequencing FSM for the chess clock. Converts debounced player, start and pause buttons plus per-player timeout flags into the SELECT/STOP/END controls that drive the player-enable switch. Also emits one-cycle Fischer increment pulses and a half-move counter. Sits between the button debouncers and the switch/countdown datapath.

## Interface
- MOVE_W, 10: half-move counter width.
- INC_EN, 1: 1 = generate INC_P1/INC_P2 pulses; 0 = outputs tied low.
- CLK  in  1  system clock; all state on rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- BTN_START  in  1  debounced level; rising edge starts the game.
- BTN_PAUSE  in  1  debounced level; rising edge toggles pause.
- BTN_P1  in  1  debounced level; rising edge = P1 ends turn.
- BTN_P2  in  1  debounced level; rising edge = P2 ends turn.
- TIMEOUT_P1  in  1  level from P1 countdown; 1 = time exhausted.
- TIMEOUT_P2  in  1  level from P2 countdown; 1 = time exhausted.
- SELECT  out  1  0 = P1 clock runs, 1 = P2 clock runs.
- STOP  out  1  1 = both clocks halted.
- END  out  1  1 = game over; enables frozen.
- INC_P1  out  1  one-cycle pulse: add increment to P1.
- INC_P2  out  1  one-cycle pulse: add increment to P2.
- MOVES  out  MOVE_W  half-moves completed, saturating.
- WINNER  out  2  00 none, 01 P1, 10 P2.
- STATE  out  3  current FSM state encoding (debug/display).

## Operation
- Rising-edge detection on every BTN_* input: press = input high now, low in the previous cycle. Previous-sample registers reset to 1, so a button held through reset does not fire.
- FSM states: IDLE, RUN_P1, RUN_P2, PAUSED, OVER.
- IDLE → RUN_P1 on START press. P1 (white) always moves first. MOVES cleared to 0 and WINNER cleared to 00 on this transition.
- RUN_P1 → RUN_P2 on a P1 press. Effects: INC_P1 pulse, MOVES+1.
- RUN_P2 → RUN_P1 on a P2 press. Effects: INC_P2 pulse, MOVES+1.
- Presses by the non-running player are ignored.
- RUN_Px → PAUSED on a PAUSE press. The running player is remembered in a side register.
- PAUSED → remembered RUN_Px on a PAUSE press. P1/P2 presses are ignored while paused.
- RUN_P1 with TIMEOUT_P1=1 → OVER, WINNER=10.
- RUN_P2 with TIMEOUT_P2=1 → OVER, WINNER=01.
- Timeouts are ignored in IDLE and PAUSED.
- OVER → IDLE on a START press. WINNER and MOVES are held until the next IDLE → RUN_P1 transition.
- Priority within one cycle, highest first: timeout of the running player, PAUSE, player press. A turn press coincident with the running player's timeout yields OVER with no INC pulse and no MOVES change.
- Simultaneous P1 and P2 presses: only the running player's press acts.
- MOVES saturates at all-ones; no wrap.
- Output decode by state:
  - IDLE: STOP=1, END=0.
  - RUN_P1: SELECT=0, STOP=0, END=0.
  - RUN_P2: SELECT=1, STOP=0, END=0.
  - PAUSED: STOP=1, SELECT holds its last value.
  - OVER: STOP=1, END=1, SELECT holds its last value.

## Timing
- All outputs are registered (Moore). A press sampled at edge k changes state and outputs at edge k+1, because the edge detector needs one register stage.
- TIMEOUT_Px is sampled directly: level high at edge k puts OVER on the outputs after edge k.
- INC_Px is high for exactly one cycle, coincident with the first cycle of the new RUN state.
- CLR_N low asynchronously forces: state=IDLE, SELECT=0, STOP=1, END=0, INC_P1=INC_P2=0, MOVES=0, WINNER=00, edge registers=1.
- CLR_N deassertion is taken synchronously. The first press can be accepted one cycle after release.
- Reset mid-game discards all state; no increment is issued.

## Structure
- Package `chess_pkg`:
  - state enum/localparams for IDLE, RUN_P1, RUN_P2, PAUSED, OVER;
  - WINNER codes;
  - player id constants P1=0, P2=1.
- Sub-module `edge_detect`: 1-bit rising-edge pulse generator with async active-low reset, preset value 1. Instantiated four times.
- Everything else in one FSM process plus an output register process.

## Test plan
- Reset then START press → after 2 cycles SELECT=0, STOP=0, END=0, MOVES=0.
- P1 press, then P2 press → SELECT 0→1→0; INC_P1 then INC_P2 each high for exactly 1 cycle; MOVES=2. A P2 press during RUN_P1 is ignored and MOVES is unchanged.
- PAUSE in RUN_P2 → STOP=1, SELECT=1. P2 press ignored. Second PAUSE → RUN_P2, STOP=0.
- TIMEOUT_P1=1 in RUN_P1, same cycle as a P1 press → END=1, STOP=1, WINNER=10, no INC_P1, MOVES unchanged.
- MOVE_W=2 with 5 turn presses → MOVES sticks at 3.
- CLR_N pulsed low mid-RUN_P2 while BTN_P2 is held high → immediate STOP=1, SELECT=0, MOVES=0. No press detected after release until BTN_P2 goes low and high again.
